// File: rtl/char_buf_scroll_ctrl.sv
// char_buf_scroll_ctrl: owns port 1 of the character-buffer SRAM. It arbitrates
// between CPU accesses and an internal engine that clears the screen or scrolls
// it up one text row, and exposes a small control/status slave with an interrupt.
module char_buf_scroll_ctrl #(
    parameter int ROWS      = 60,
    parameter int COL_WORDS = 20,
    parameter int ROW_SHIFT = 5,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] s_address,
    input  logic              s_chipselect,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [3:0]        s_byteenable,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    output logic              s_waitrequest,
    input  logic [1:0]        ctl_address,
    input  logic              ctl_read,
    input  logic              ctl_write,
    input  logic [31:0]       ctl_writedata,
    output logic [31:0]       ctl_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic [31:0]       m_readdata
);
    // Row index occupies the address bits above the column field.
    localparam int ROW_W = ADDR_W - ROW_SHIFT;
    localparam int COL_W = ROW_SHIFT;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COL_WORDS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CPU_RD, ST_CLR, ST_SCR_RD, ST_SCR_WR, ST_FILL
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              pending_q, pending_d;
    logic              cmd_scroll_q, cmd_scroll_d;
    logic              done_q, done_d;
    logic              dropped_q, dropped_d;
    logic              irq_en_q, irq_en_d;
    logic [7:0]        fill_q, fill_d;
    logic [15:0]       ops_done_q, ops_done_d;

    logic              busy, cmd_req, accept, finish;
    logic [31:0]       fill_word;
    logic              unused_wdata;

    assign unused_wdata = ^ctl_writedata[31:9];

    // Stride is a power of two, so (row << ROW_SHIFT) + col is a concatenation.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
        return {r, c};
    endfunction

    assign busy      = (state_q == ST_CLR) || (state_q == ST_SCR_RD) ||
                       (state_q == ST_SCR_WR) || (state_q == ST_FILL);
    assign cmd_req   = ctl_write && (ctl_address == 2'd0) &&
                       (ctl_writedata[0] || ctl_writedata[1]);
    assign accept    = cmd_req && !busy && !pending_q;
    assign fill_word = {4{fill_q}};
    assign irq       = done_q & irq_en_q;
    assign m_clken   = 1'b1;

    // State and register file; reset aborts any engine operation immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            pending_q    <= 1'b0;
            cmd_scroll_q <= 1'b0;
            done_q       <= 1'b0;
            dropped_q    <= 1'b0;
            irq_en_q     <= 1'b0;
            fill_q       <= '0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pending_q    <= pending_d;
            cmd_scroll_q <= cmd_scroll_d;
            done_q       <= done_d;
            dropped_q    <= dropped_d;
            irq_en_q     <= irq_en_d;
            fill_q       <= fill_d;
            ops_done_q   <= ops_done_d;
        end
    end

    // Next-state, SRAM port drive, CPU handshake and register updates.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        pending_d     = pending_q;
        cmd_scroll_d  = cmd_scroll_q;
        done_d        = done_q;
        dropped_d     = dropped_q;
        irq_en_d      = irq_en_q;
        fill_d        = fill_q;
        ops_done_d    = ops_done_q;
        finish        = 1'b0;
        m_address     = '0;
        m_chipselect  = 1'b0;
        m_write       = 1'b0;
        m_byteenable  = 4'h0;
        m_writedata   = '0;
        s_readdata    = '0;
        // Any CPU request stalls unless a state below grants it.
        s_waitrequest = s_chipselect && (s_read || s_write);

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    // A queued engine command takes priority over the CPU.
                    pending_d = 1'b0;
                    state_d   = cmd_scroll_q ? ST_SCR_RD : ST_CLR;
                    row_d     = cmd_scroll_q ? ROW_ONE : '0;
                    col_d     = '0;
                end else if (s_chipselect && s_write) begin
                    m_chipselect  = 1'b1;
                    m_write       = 1'b1;
                    m_address     = s_address;
                    m_byteenable  = s_byteenable;
                    m_writedata   = s_writedata;
                    s_waitrequest = 1'b0;
                end else if (s_chipselect && s_read) begin
                    m_chipselect  = 1'b1;
                    m_address     = s_address;
                    s_waitrequest = 1'b1;
                    state_d       = ST_CPU_RD;
                end
            end
            ST_CPU_RD: begin
                s_readdata    = m_readdata;
                s_waitrequest = 1'b0;
                state_d       = ST_IDLE;
                // A command accepted during the read starts right after it.
                if (pending_q) begin
                    pending_d = 1'b0;
                    state_d   = cmd_scroll_q ? ST_SCR_RD : ST_CLR;
                    row_d     = cmd_scroll_q ? ROW_ONE : '0;
                    col_d     = '0;
                end
            end
            ST_CLR: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = addr_of(row_q, col_q);
                m_byteenable = 4'hF;
                m_writedata  = fill_word;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    if (row_q == LAST_ROW) begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + ROW_ONE;
                    end
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            ST_SCR_RD: begin
                m_chipselect = 1'b1;
                m_address    = addr_of(row_q, col_q);
                state_d      = ST_SCR_WR;
            end
            ST_SCR_WR: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = addr_of(row_q - ROW_ONE, col_q);
                m_byteenable = 4'hF;
                m_writedata  = m_readdata;
                state_d      = ST_SCR_RD;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    if (row_q == LAST_ROW) begin
                        state_d = ST_FILL;
                    end else begin
                        row_d = row_q + ROW_ONE;
                    end
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            ST_FILL: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = addr_of(LAST_ROW, col_q);
                m_byteenable = 4'hF;
                m_writedata  = fill_word;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Control register writes: W1C clears first so same-cycle sets win.
        if (ctl_write && ctl_address == 2'd0) begin
            irq_en_d = ctl_writedata[8];
            if (ctl_writedata[4]) done_d    = 1'b0;
            if (ctl_writedata[5]) dropped_d = 1'b0;
        end
        if (ctl_write && ctl_address == 2'd1) begin
            fill_d = ctl_writedata[7:0];
        end
        if (accept) begin
            pending_d    = 1'b1;
            cmd_scroll_d = ctl_writedata[1] && !ctl_writedata[0];
        end else if (cmd_req) begin
            dropped_d = 1'b1;
        end
        if (finish) begin
            done_d     = 1'b1;
            ops_done_d = ops_done_q + 16'd1;
        end
    end

    // Zero-wait register read mux.
    always_comb begin
        ctl_readdata = '0;
        if (ctl_read) begin
            case (ctl_address)
                2'd0: begin
                    ctl_readdata[0] = busy;
                    ctl_readdata[1] = pending_q;
                    ctl_readdata[4] = done_q;
                    ctl_readdata[5] = dropped_q;
                    ctl_readdata[8] = irq_en_q;
                end
                2'd1:    ctl_readdata = {24'd0, fill_q};
                2'd2:    ctl_readdata = {16'd0, ops_done_q};
                default: ctl_readdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_char_buf_scroll_ctrl.sv
// Directed bench for char_buf_scroll_ctrl with a behavioural 2048x32 SRAM.
module tb_char_buf_scroll_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] s_address;
    logic        s_chipselect, s_read, s_write;
    logic [3:0]  s_byteenable;
    logic [31:0] s_writedata, s_readdata;
    logic        s_waitrequest;
    logic [1:0]  ctl_address;
    logic        ctl_read, ctl_write;
    logic [31:0] ctl_writedata, ctl_readdata;
    logic        irq;
    logic [10:0] m_address;
    logic        m_chipselect, m_write, m_clken;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;
    logic [31:0] mem [0:2047];

    char_buf_scroll_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_read(s_read),
        .s_write(s_write), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .ctl_address(ctl_address), .ctl_read(ctl_read), .ctl_write(ctl_write),
        .ctl_writedata(ctl_writedata), .ctl_readdata(ctl_readdata), .irq(irq),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_clken(m_clken),
        .m_readdata(m_readdata)
    );

    always #5 clk = ~clk;

    // SRAM model: byte-enabled write, one-cycle registered read.
    always @(posedge clk) begin
        if (m_chipselect && m_clken) begin
            if (m_write) begin
                for (int b = 0; b < 4; b++)
                    if (m_byteenable[b]) mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
                wr_count <= wr_count + 1;
            end
            m_readdata <= mem[m_address];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic cpu_wr(input logic [10:0] a, input logic [31:0] d, output int cyc);
        @(negedge clk);
        s_chipselect = 1'b1; s_write = 1'b1; s_address = a;
        s_writedata = d; s_byteenable = 4'hF;
        cyc = 1;
        #1;
        while (s_waitrequest && cyc < 6000) begin
            @(negedge clk); #1; cyc++;
        end
        if (s_waitrequest) check_val("cpu_wr_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        s_chipselect = 1'b0; s_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [10:0] a, output logic [31:0] d, output int cyc);
        @(negedge clk);
        s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
        cyc = 1;
        #1;
        while (s_waitrequest && cyc < 6000) begin
            @(negedge clk); #1; cyc++;
        end
        if (s_waitrequest) check_val("cpu_rd_timeout", 32'd1, 32'd0);
        d = s_readdata;
        @(posedge clk); #1;
        s_chipselect = 1'b0; s_read = 1'b0;
    endtask

    task automatic ctl_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        ctl_write = 1'b1; ctl_address = a; ctl_writedata = d;
        @(negedge clk);
        ctl_write = 1'b0;
    endtask

    task automatic ctl_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        ctl_read = 1'b1; ctl_address = a;
        #1;
        d = ctl_readdata;
        ctl_read = 1'b0;
    endtask

    // Waits for busy to rise, then counts busy cycles; optionally issues a
    // second command 100 cycles into the operation.
    task automatic run_busy(input logic [31:0] drop_cmd, output int n);
        int k;
        k = 0; n = 0;
        @(negedge clk);
        ctl_read = 1'b1; ctl_address = 2'd0;
        #1;
        while (!ctl_readdata[0] && k < 20) begin
            @(negedge clk); #1; k++;
        end
        if (!ctl_readdata[0]) check_val("busy_start", 32'd0, 32'd1);
        while (ctl_readdata[0] && n < 6000) begin
            n++;
            ctl_write = (n == 100) && (drop_cmd != 32'd0);
            ctl_writedata = drop_cmd;
            @(negedge clk); #1;
        end
        ctl_read = 1'b0; ctl_write = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int c, n, wc;
        reset_n = 1'b0;
        s_address = '0; s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0;
        s_byteenable = '0; s_writedata = '0;
        ctl_address = '0; ctl_read = 1'b0; ctl_write = 1'b0; ctl_writedata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_waitrequest", {31'd0, s_waitrequest}, 32'd0);
        check_val("rst_readdata", s_readdata, 32'd0);
        check_val("rst_m_strobes", {30'd0, m_chipselect, m_write}, 32'd0);
        check_val("rst_m_clken", {31'd0, m_clken}, 32'd1);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        ctl_rd(2'd0, d); check_val("rst_reg0", d, 32'd0);
        ctl_rd(2'd2, d); check_val("rst_ops_done", d, 32'd0);

        // Basic CPU write / read
        cpu_wr(11'd5, 32'h41424344, c);
        check_val("wr_cycles", c, 32'd1);
        cpu_rd(11'd5, d, c);
        check_val("rd_data", d, 32'h41424344);
        check_val("rd_cycles", c, 32'd2);

        // CLEAR with FILL=0x20
        ctl_wr(2'd1, 32'h20);
        ctl_rd(2'd1, d); check_val("fill_reg", d, 32'h20);
        cpu_wr(11'd20, 32'hDEADBEEF, c);
        ctl_wr(2'd0, 32'h1);
        run_busy(32'd0, n);
        check_val("clear_busy_cycles", n, 32'd1200);
        ctl_rd(2'd0, d); check_val("clear_reg0", d, 32'h10);
        ctl_rd(2'd2, d); check_val("clear_ops_done", d, 32'd1);
        cpu_rd(11'd0, d, c);    check_val("clear_r0c0", d, 32'h20202020);
        cpu_rd(11'd1907, d, c); check_val("clear_r59c19", d, 32'h20202020);
        cpu_rd(11'd20, d, c);   check_val("clear_r0c20", d, 32'hDEADBEEF);

        // Preload rows with {r,c,r,c}, then SCROLL with a dropped second command
        for (int r = 0; r < 60; r++)
            for (int col = 0; col < 20; col++)
                cpu_wr(11'(r * 32 + col), {r[7:0], col[7:0], r[7:0], col[7:0]}, c);
        ctl_wr(2'd0, 32'h12);
        run_busy(32'h1, n);
        check_val("scroll_busy_cycles", n, 32'd2380);
        ctl_rd(2'd0, d); check_val("scroll_reg0", d, 32'h30);
        ctl_rd(2'd2, d); check_val("scroll_ops_done", d, 32'd2);
        cpu_rd(11'd3, d, c);    check_val("scroll_r0c3", d, 32'h01030103);
        cpu_rd(11'd1863, d, c); check_val("scroll_r58c7", d, 32'h3B073B07);
        cpu_rd(11'd1875, d, c); check_val("scroll_r58c19", d, 32'h3B133B13);
        cpu_rd(11'd1888, d, c); check_val("scroll_r59c0", d, 32'h20202020);
        cpu_rd(11'd1907, d, c); check_val("scroll_r59c19", d, 32'h20202020);
        cpu_rd(11'd20, d, c);   check_val("scroll_r0c20", d, 32'hDEADBEEF);

        // CPU read issued while a SCROLL is pending/running
        ctl_wr(2'd0, 32'h2);
        cpu_rd(11'd3, d, c);
        check_val("stall_rd_data", d, 32'h02030203);
        check_val("stall_rd_cycles_in_range", {31'd0, (c >= 2380 && c <= 2383)}, 32'd1);
        ctl_rd(2'd2, d); check_val("stall_ops_done", d, 32'd3);

        // Interrupt
        ctl_wr(2'd0, 32'h130);
        ctl_rd(2'd0, d); check_val("irq_en_reg0", d, 32'h100);
        check_val("irq_before", {31'd0, irq}, 32'd0);
        ctl_wr(2'd0, 32'h101);
        run_busy(32'd0, n);
        check_val("irq_clear_cycles", n, 32'd1200);
        @(negedge clk); #1;
        check_val("irq_after_done", {31'd0, irq}, 32'd1);
        ctl_wr(2'd0, 32'h110);
        #1;
        check_val("irq_after_w1c", {31'd0, irq}, 32'd0);
        ctl_rd(2'd2, d); check_val("irq_ops_done", d, 32'd4);

        // Reset in the middle of a scroll
        ctl_wr(2'd0, 32'h102);
        repeat (60) @(negedge clk);
        reset_n = 1'b0;
        #1;
        wc = wr_count;
        check_val("midrst_m_strobes", {30'd0, m_chipselect, m_write}, 32'd0);
        check_val("midrst_m_clken", {31'd0, m_clken}, 32'd1);
        check_val("midrst_irq", {31'd0, irq}, 32'd0);
        check_val("midrst_waitrequest", {31'd0, s_waitrequest}, 32'd0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        check_val("midrst_no_writes", wr_count, wc);
        ctl_rd(2'd0, d); check_val("midrst_reg0", d, 32'd0);
        ctl_rd(2'd2, d); check_val("midrst_ops_done", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
